pong_score_unit: RTL and testbench

// - Score datapath and score/end-game overlay source for the pong top level.
// - Counts points for P1/P2 from wall-hit pulses and splits each score into tens/units 7-seg patterns.
// - Generates a per-pixel mask drawing the word "END" at a fixed screen position.
// - The display_seg instances and the RGB mux in the top level consume these outputs.

---
 rtl/pong_pkg.sv | 50 +++++
 rtl/pong_score_unit_score_to_seg.sv | 32 +++
 rtl/pong_score_unit.sv | 135 +++++++++++++
 tb/tb_pong_score_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared constants for the pong design: 7-segment digit patterns, screen
// size and the glyph ROM used by the "END" overlay.
// No ports; imported by pong_score_unit and score_to_seg.
package pong_pkg;

  // 7-segment patterns, seg[6:0] = {a,b,c,d,e,f,g}, active-high.
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam int unsigned H_SCREEN = 640;
  localparam int unsigned V_SCREEN = 480;

  // 5-bit glyph rows, MSB = leftmost column. Row 7 is padding so any
  // 3-bit row index stays in range; it is never inside the text box.
  localparam logic [4:0] GLYPH_E [0:7] = '{5'b11111, 5'b10000, 5'b10000, 5'b11110,
                                           5'b10000, 5'b10000, 5'b11111, 5'b00000};
  localparam logic [4:0] GLYPH_N [0:7] = '{5'b10001, 5'b11001, 5'b10101, 5'b10011,
                                           5'b10001, 5'b10001, 5'b10001, 5'b00000};
  localparam logic [4:0] GLYPH_D [0:7] = '{5'b11110, 5'b10001, 5'b10001, 5'b10001,
                                           5'b10001, 5'b10001, 5'b11110, 5'b00000};

  // Decimal digit to 7-segment pattern; anything above 9 is blank.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/pong_score_unit_score_to_seg.sv
// score_to_seg: splits a binary score into tens/units and encodes each
// digit as a 7-segment pattern. Purely combinational; the leading zero
// is kept so a score of 7 shows "07".
// Ports: score (W bits in), seg_tens / seg_ones (7 bits out each).
module score_to_seg
  import pong_pkg::*;
#(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] score,
  input  logic         unused_tie,
  output logic [6:0]   seg_tens,
  output logic [6:0]   seg_ones
);

  localparam logic [W-1:0] TEN = W'(10);

  logic [W-1:0] tens_s;
  logic [W-1:0] ones_s;

  // Decimal split and digit encoding.
  always_comb begin
    tens_s   = score / TEN;
    ones_s   = score % TEN;
    seg_tens = seg_encode(4'(tens_s));
    seg_ones = seg_encode(4'(ones_s));
  end

  logic unused_s;
  assign unused_s = unused_tie;

endmodule

// File: rtl/pong_score_unit.sv
// pong_score_unit: score counters for both players, 7-segment digit
// patterns for each score, and a per-pixel mask for the "END" text.
// Ports:
//   clk, reset (async, active-low), clear (sync score clear)
//   hit_right / hit_left : wall-hit levels, rising edge scores a point
//   x, y                 : current scan position
//   score_p1, score_p2   : saturating scores
//   seg_p{1,2}_{tens,ones}: 7-seg patterns {a..g}, active-high
//   end_pixel            : (x,y) is on a lit pixel of "END"
module pong_score_unit
  import pong_pkg::*;
#(
  parameter int unsigned SCORE_W  = 5,
  parameter int unsigned ORIGIN_X = 276,
  parameter int unsigned ORIGIN_Y = 220,
  parameter int unsigned SCALE_LG = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               hit_right,
  input  logic               hit_left,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic [6:0]         seg_p1_tens,
  output logic [6:0]         seg_p1_ones,
  output logic [6:0]         seg_p2_tens,
  output logic [6:0]         seg_p2_ones,
  output logic               end_pixel
);

  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [9:0] X_LO = 10'(ORIGIN_X);
  localparam logic [9:0] X_HI = 10'(ORIGIN_X + (17 << SCALE_LG));
  localparam logic [9:0] Y_LO = 10'(ORIGIN_Y);
  localparam logic [9:0] Y_HI = 10'(ORIGIN_Y + (7 << SCALE_LG));

  logic               hit_right_r;
  logic               hit_left_r;
  logic [SCORE_W-1:0] score_p1_r;
  logic [SCORE_W-1:0] score_p2_r;
  logic               inc_p1_s;
  logic               inc_p2_s;

  assign inc_p1_s = hit_right & ~hit_right_r;
  assign inc_p2_s = hit_left & ~hit_left_r;

  // Edge history and saturating score counters; clear wins over a
  // coincident edge, but the history still advances so that edge is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_right_r <= 1'b0;
      hit_left_r  <= 1'b0;
      score_p1_r  <= '0;
      score_p2_r  <= '0;
    end else begin
      hit_right_r <= hit_right;
      hit_left_r  <= hit_left;
      if (clear) begin
        score_p1_r <= '0;
        score_p2_r <= '0;
      end else begin
        if (inc_p1_s && (score_p1_r != SCORE_MAX)) begin
          score_p1_r <= score_p1_r + SCORE_W'(1);
        end
        if (inc_p2_s && (score_p2_r != SCORE_MAX)) begin
          score_p2_r <= score_p2_r + SCORE_W'(1);
        end
      end
    end
  end

  assign score_p1 = score_p1_r;
  assign score_p2 = score_p2_r;

  score_to_seg #(.W(SCORE_W)) u_seg_p1 (
    .score      (score_p1_r),
    .unused_tie (1'b0),
    .seg_tens   (seg_p1_tens),
    .seg_ones   (seg_p1_ones)
  );

  score_to_seg #(.W(SCORE_W)) u_seg_p2 (
    .score      (score_p2_r),
    .unused_tie (1'b0),
    .seg_tens   (seg_p2_tens),
    .seg_ones   (seg_p2_ones)
  );

  // Overlay: left combinational so it lines up with the caller's own
  // RGB register. The box test gates everything, so the offset
  // subtraction below never contributes when it would underflow.
  logic       in_box_s;
  logic [9:0] dx_s;
  logic [9:0] dy_s;
  logic [4:0] col_s;
  logic [2:0] row_s;
  logic [1:0] char_s;
  logic [2:0] bit_s;
  logic [4:0] glyph_row_s;

  // Box test, cell addressing and glyph lookup.
  always_comb begin
    in_box_s = (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);
    dx_s     = x - X_LO;
    dy_s     = y - Y_LO;
    col_s    = 5'(dx_s >> SCALE_LG);
    row_s    = 3'(dy_s >> SCALE_LG);
    // Six-cell character pitch: column 5 of each pitch is the spacer.
    if (col_s < 5'd6) begin
      char_s = 2'd0;
      bit_s  = 3'(col_s);
    end else if (col_s < 5'd12) begin
      char_s = 2'd1;
      bit_s  = 3'(col_s - 5'd6);
    end else begin
      char_s = 2'd2;
      bit_s  = 3'(col_s - 5'd12);
    end
    case (char_s)
      2'd0:    glyph_row_s = GLYPH_E[row_s];
      2'd1:    glyph_row_s = GLYPH_N[row_s];
      2'd2:    glyph_row_s = GLYPH_D[row_s];
      default: glyph_row_s = 5'b00000;
    endcase
    if (in_box_s && (bit_s < 3'd5)) begin
      end_pixel = glyph_row_s[3'd4 - bit_s];
    end else begin
      end_pixel = 1'b0;
    end
  end

endmodule

// File: tb/tb_pong_score_unit.sv
// Directed self-checking bench for pong_score_unit at default parameters.
module tb_pong_score_unit;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       hit_right;
  logic       hit_left;
  logic [9:0] x;
  logic [9:0] y;
  logic [4:0] score_p1;
  logic [4:0] score_p2;
  logic [6:0] seg_p1_tens;
  logic [6:0] seg_p1_ones;
  logic [6:0] seg_p2_tens;
  logic [6:0] seg_p2_ones;
  logic       end_pixel;

  int errors = 0;
  int checks = 0;

  pong_score_unit dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .hit_right   (hit_right),
    .hit_left    (hit_left),
    .x           (x),
    .y           (y),
    .score_p1    (score_p1),
    .score_p2    (score_p2),
    .seg_p1_tens (seg_p1_tens),
    .seg_p1_ones (seg_p1_ones),
    .seg_p2_tens (seg_p2_tens),
    .seg_p2_ones (seg_p2_ones),
    .end_pixel   (end_pixel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pulse_right();
    @(negedge clk); hit_right = 1'b1;
    @(negedge clk); hit_right = 1'b0;
  endtask

  task automatic pulse_left();
    @(negedge clk); hit_left = 1'b1;
    @(negedge clk); hit_left = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; clear = 1'b0; hit_right = 1'b0; hit_left = 1'b0;
    x = 10'd0; y = 10'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (score_p1 !== 5'd0 || score_p2 !== 5'd0) begin
      errors++; $display("FAIL reset_scores: got %0d/%0d want 0/0", score_p1, score_p2);
    end
    checks++;
    if ({seg_p1_tens, seg_p1_ones, seg_p2_tens, seg_p2_ones} !== {4{7'b1111110}}) begin
      errors++; $display("FAIL reset_segs: got %b %b %b %b want all 1111110",
                         seg_p1_tens, seg_p1_ones, seg_p2_tens, seg_p2_ones);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_hold();
    @(negedge clk); hit_right = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (score_p1 !== 5'd1) begin
      errors++; $display("FAIL hold_once: got %0d want 1", score_p1);
    end
    hit_right = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_pulses();
    do_clear();
    checks++;
    if (score_p1 !== 5'd0) begin
      errors++; $display("FAIL clear: got %0d want 0", score_p1);
    end
    repeat (3) pulse_right();
    checks++;
    if (score_p1 !== 5'd3 || seg_p1_ones !== 7'b1111001 || seg_p1_tens !== 7'b1111110) begin
      errors++; $display("FAIL three_pulses: got %0d %b %b want 3 1111110 1111001",
                         score_p1, seg_p1_tens, seg_p1_ones);
    end
    checks++;
    if (score_p2 !== 5'd0) begin
      errors++; $display("FAIL p2_untouched: got %0d want 0", score_p2);
    end
  endtask

  task automatic test_back_to_back();
    // both rise on the same clock
    @(negedge clk); hit_right = 1'b1; hit_left = 1'b1;
    @(negedge clk); hit_right = 1'b0; hit_left = 1'b0;
    checks++;
    if (score_p1 !== 5'd4 || score_p2 !== 5'd1) begin
      errors++; $display("FAIL simultaneous: got %0d/%0d want 4/1", score_p1, score_p2);
    end
    // both rise together with clear: clear wins, edge is consumed
    @(negedge clk); hit_right = 1'b1; hit_left = 1'b1; clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    checks++;
    if (score_p1 !== 5'd0 || score_p2 !== 5'd0) begin
      errors++; $display("FAIL clear_priority: got %0d/%0d want 0/0", score_p1, score_p2);
    end
    @(negedge clk);
    checks++;
    if (score_p1 !== 5'd0 || score_p2 !== 5'd0) begin
      errors++; $display("FAIL edge_lost: got %0d/%0d want 0/0", score_p1, score_p2);
    end
    hit_right = 1'b0; hit_left = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_saturate();
    repeat (35) pulse_left();
    checks++;
    if (score_p2 !== 5'd31) begin
      errors++; $display("FAIL saturate: got %0d want 31", score_p2);
    end
    checks++;
    if (seg_p2_tens !== 7'b1111001 || seg_p2_ones !== 7'b0110000) begin
      errors++; $display("FAIL saturate_segs: got %b %b want 1111001 0110000", seg_p2_tens, seg_p2_ones);
    end
  endtask

  task automatic test_async_reset();
    do_clear();
    repeat (12) pulse_right();
    checks++;
    if (score_p1 !== 5'd12 || seg_p1_tens !== 7'b0110000 || seg_p1_ones !== 7'b1101101) begin
      errors++; $display("FAIL twelve: got %0d %b %b want 12 0110000 1101101",
                         score_p1, seg_p1_tens, seg_p1_ones);
    end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (score_p1 !== 5'd0 || seg_p1_tens !== 7'b1111110 || seg_p1_ones !== 7'b1111110) begin
      errors++; $display("FAIL async_reset: got %0d %b %b want 0 1111110 1111110",
                         score_p1, seg_p1_tens, seg_p1_ones);
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_overlay();
    logic [9:0] px [0:13];
    logic [9:0] py [0:13];
    logic       exp_v [0:13];
    px = '{10'd276, 10'd296, 10'd300, 10'd275, 10'd344, 10'd292, 10'd336,
           10'd340, 10'd343, 10'd276, 10'd280, 10'd276, 10'd276, 10'd0};
    py = '{10'd220, 10'd220, 10'd224, 10'd220, 10'd220, 10'd220, 10'd244,
           10'd244, 10'd247, 10'd247, 10'd228, 10'd248, 10'd219, 10'd0};
    exp_v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
              1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      x = px[i]; y = py[i];
      #1;
      checks++;
      if (end_pixel !== exp_v[i]) begin
        errors++; $display("FAIL overlay(%0d,%0d): got %b want %b", px[i], py[i], end_pixel, exp_v[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_pulses();
    test_back_to_back();
    test_saturate();
    test_async_reset();
    test_overlay();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
